csi2_4to1_pkt_arbiter: RTL

- Schedules packets from NUM_CH independent CSI-2 capture channels onto the single downstream TX packet builder of the 4-to-1 aggregator.
- Each capture channel posts a decoded packet header and then streams its payload from a show-ahead buffer.
- The arbiter grants channels round-robin, rewrites the VC to the channel index, and meters payload beats against WC.
- It enforces a minimum inter-packet gap at the TX side.

---
 rtl/csi2_4to1_pkg.sv | 21 ++
 rtl/csi2_rr_arbiter.sv | 50 +++++
 rtl/csi2_4to1_pkt_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/csi2_4to1_pkg.sv
// Shared definitions for the CSI-2 4-to-1 aggregator: data types, arbiter
// FSM encoding and the channel-index width helper.
package csi2_4to1_pkg;

   localparam logic [5:0] DT_FS = 6'h00;
   localparam logic [5:0] DT_FE = 6'h01;
   localparam logic [5:0] DT_LS = 6'h02;
   localparam logic [5:0] DT_LE = 6'h03;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_GAP
   } arb_state_t;

   function automatic int chan_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/csi2_rr_arbiter.sv
// Round-robin requester select with a registered pointer; the requester
// after the last winner has top priority. Shared by other aggregator users.
module csi2_rr_arbiter
   import csi2_4to1_pkg::*;
#(
   parameter int N = 4,
   localparam int IW = chan_idx_w(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] ptr;
   logic [IW-1:0] pos;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      if (s >= N) s = s - N;
      return IW'(s);
   endfunction

   // Walk from farthest to nearest so the nearest requester after ptr wins.
   always_comb begin
      gnt = '0;
      idx = '0;
      pos = '0;
      for (int k = N; k >= 1; k--) begin
         pos = wrap_add(ptr, k);
         if (req[pos]) begin
            gnt      = '0;
            gnt[pos] = 1'b1;
            idx      = pos;
         end
      end
   end

   assign any = |req;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr <= IW'(N - 1);
      else if (advance && any) ptr <= idx;
   end

endmodule

// File: rtl/csi2_4to1_pkt_arbiter.sv
// Schedules headers and payload from NUM_CH capture channels onto the single
// TX packet builder, with VC remap, WC-metered beats and a minimum packet gap.
module csi2_4to1_pkt_arbiter
   import csi2_4to1_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_BYTES = 4,
   parameter int GAP_CYC    = 4,
   parameter int VC_REMAP   = 1,
   localparam int IW  = chan_idx_w(NUM_CH),
   localparam int DW  = 8 * DATA_BYTES,
   localparam int LBW = $clog2(DATA_BYTES) + 1
) (
   input  logic                 clk_byte_i,
   input  logic                 reset_i,
   input  logic [NUM_CH-1:0]    ch_req_i,
   input  logic [NUM_CH-1:0]    ch_lp_i,
   input  logic [2*NUM_CH-1:0]  ch_vc_i,
   input  logic [6*NUM_CH-1:0]  ch_dt_i,
   input  logic [16*NUM_CH-1:0] ch_wc_i,
   input  logic [DW*NUM_CH-1:0] ch_payload_i,
   output logic [NUM_CH-1:0]    ch_gnt_o,
   output logic [NUM_CH-1:0]    ch_rd_o,
   input  logic                 tx_ready_i,
   output logic                 tx_sp_en_o,
   output logic                 tx_lp_en_o,
   output logic [1:0]           tx_vc_o,
   output logic [5:0]           tx_dt_o,
   output logic [15:0]          tx_wc_o,
   output logic                 tx_payload_en_o,
   output logic [DW-1:0]        tx_payload_o,
   output logic                 tx_last_o,
   output logic [LBW-1:0]       tx_last_bytes_o,
   output logic                 busy_o,
   output logic [1:0]           cur_ch_o
);

   arb_state_t        state, next_state;
   logic [NUM_CH-1:0] arb_gnt;
   logic [IW-1:0]     arb_idx, cur;
   logic              arb_any, grant, last_beat;
   logic              lat_lp;
   logic [1:0]        lat_vc;
   logic [5:0]        lat_dt;
   logic [15:0]       lat_wc, rem;
   logic [3:0]        gap_cnt;

   assign grant     = (state == ST_IDLE) && tx_ready_i && arb_any;
   assign last_beat = (rem <= 16'(DATA_BYTES));

   csi2_rr_arbiter #(.N(NUM_CH)) u_rr (
      .clk     (clk_byte_i),
      .rst     (reset_i),
      .req     (ch_req_i),
      .advance (grant),
      .gnt     (arb_gnt),
      .idx     (arb_idx),
      .any     (arb_any)
   );

   always_ff @(posedge clk_byte_i or posedge reset_i) begin
      if (reset_i) state <= ST_IDLE;
      else         state <= next_state;
   end

   // The pop strobe is issued in the same cycle the show-ahead word is
   // captured, so the channel head advances in lockstep with each beat.
   always_comb begin
      next_state = state;
      ch_rd_o    = '0;
      case (state)
         ST_IDLE:    if (grant) next_state = ST_HDR;
         ST_HDR:     next_state = (lat_lp && lat_wc != 16'd0) ? ST_PAYLOAD : ST_GAP;
         ST_PAYLOAD: begin
            if (tx_ready_i) begin
               ch_rd_o[cur] = 1'b1;
               if (last_beat) next_state = ST_GAP;
            end
         end
         ST_GAP:     if (gap_cnt == 4'(GAP_CYC - 1)) next_state = ST_IDLE;
         default:    next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_byte_i or posedge reset_i) begin
      if (reset_i) begin
         ch_gnt_o        <= '0;
         tx_sp_en_o      <= 1'b0;
         tx_lp_en_o      <= 1'b0;
         tx_vc_o         <= '0;
         tx_dt_o         <= '0;
         tx_wc_o         <= '0;
         tx_payload_en_o <= 1'b0;
         tx_payload_o    <= '0;
         tx_last_o       <= 1'b0;
         tx_last_bytes_o <= '0;
         busy_o          <= 1'b0;
         cur_ch_o        <= '0;
         cur             <= '0;
         lat_lp          <= 1'b0;
         lat_vc          <= '0;
         lat_dt          <= '0;
         lat_wc          <= '0;
         rem             <= '0;
         gap_cnt         <= '0;
      end else begin
         ch_gnt_o        <= '0;
         tx_sp_en_o      <= 1'b0;
         tx_lp_en_o      <= 1'b0;
         tx_payload_en_o <= 1'b0;
         tx_last_o       <= 1'b0;
         busy_o          <= (next_state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  ch_gnt_o <= arb_gnt;
                  cur      <= arb_idx;
                  cur_ch_o <= 2'(arb_idx);
                  lat_lp   <= ch_lp_i[arb_idx];
                  lat_vc   <= ch_vc_i[2*arb_idx +: 2];
                  lat_dt   <= ch_dt_i[6*arb_idx +: 6];
                  lat_wc   <= ch_wc_i[16*arb_idx +: 16];
               end
            end
            ST_HDR: begin
               tx_lp_en_o <= lat_lp;
               tx_sp_en_o <= !lat_lp;
               tx_vc_o    <= (VC_REMAP != 0) ? 2'(cur) : lat_vc;
               tx_dt_o    <= lat_dt;
               tx_wc_o    <= lat_wc;
               rem        <= lat_wc;
               gap_cnt    <= '0;
            end
            ST_PAYLOAD: begin
               if (tx_ready_i) begin
                  tx_payload_en_o <= 1'b1;
                  tx_payload_o    <= ch_payload_i[DW*cur +: DW];
                  tx_last_o       <= last_beat;
                  if (last_beat) tx_last_bytes_o <= LBW'(rem);
                  rem             <= rem - 16'(DATA_BYTES);
               end
            end
            ST_GAP:  gap_cnt <= gap_cnt + 4'd1;
            default: ;
         endcase
      end
   end

endmodule
